alu_op_sequencer: RTL and testbench

//  Initiator side of the combinational 8-bit datapath ALU: accepts register-level commands over a

---
 rtl/alu_op_sequencer_pkg.sv | 43 ++++
 rtl/alu_op_sequencer_regfile.sv | 36 +++
 rtl/alu_op_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: ALU select codes, NZVC flag indices,
// sequencer FSM states and small decode helpers.
package alu_op_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_DIV = 4'h3,
        OP_MOD = 4'h4,
        OP_CMP = 4'h5,
        OP_AND = 4'h6,
        OP_OR  = 4'h7,
        OP_NOT = 4'h8,
        OP_XOR = 4'h9
    } alu_op_e;

    localparam logic [3:0] OP_LAST = 4'h9;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_C = 0;

    localparam logic [3:0] DIV_ZERO_FLAGS  = 4'hF;
    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

    // Compare only sets flags; every other legal op writes its result back.
    function automatic logic op_writes_back(input logic [3:0] op);
        return is_legal_op(op) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// alu_regfile: NREGS x DATA_W register file, two asynchronous read ports,
// one synchronous write port, whole array cleared by rst_n.
module alu_regfile
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [NREGS];

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    // NOTE: the array is built from flops, not a RAM macro, so it can take the async clear;
    // a RAM-backed version would have to drop this reset loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command -> register read -> ALU -> writeback/CCR -> response sequencer.
// Optional macro ALU_SEQ_STICKY_ERR_EN adds err_clr / err_sticky.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_srca,
    input  logic [ADDR_W-1:0] cmd_srcb,
    input  logic              cmd_useimm,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_nzvc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_nzvc,
    output logic              rsp_err,
    output logic [3:0]        ccr
`ifdef ALU_SEQ_STICKY_ERR_EN
    ,
    input  logic              err_clr,
    output logic              err_sticky
`endif
);

    seq_state_e        state, state_nx;
    logic [ADDR_W-1:0] dst_q;
    logic              legal_q;
    logic              accept;
    logic              div_zero;
    logic              exec_err;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (cmd_srca),
        .rdata_a (rf_rdata_a),
        .raddr_b (cmd_srcb),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (dst_q),
        .wdata   (alu_result)
    );

    assign accept   = cmd_valid && cmd_ready;
    assign div_zero = legal_q && ((alu_sel == OP_DIV) || (alu_sel == OP_MOD)) && (alu_b == '0);
    assign exec_err = !legal_q || div_zero;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // NOTE: default assignment first, so no path through the case leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)    state_nx = ST_EXEC;
            ST_EXEC:                state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        rf_we     = (state == ST_EXEC) && !div_zero && op_writes_back(alu_sel) && legal_q;
    end

    // Operands are latched at accept, so dst==src reads the old value; illegal ops park the ALU on select 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            dst_q   <= '0;
            legal_q <= 1'b0;
        end else if (accept) begin
            alu_a   <= rf_rdata_a;
            alu_b   <= cmd_useimm ? cmd_imm : rf_rdata_b;
            alu_sel <= is_legal_op(cmd_op) ? cmd_op : OP_ADD;
            dst_q   <= cmd_dst;
            legal_q <= is_legal_op(cmd_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_nzvc <= '0;
            rsp_err  <= 1'b0;
            ccr      <= '0;
        end else if (state == ST_EXEC) begin
            rsp_data <= legal_q ? alu_result : '0;
            rsp_err  <= exec_err;
            if (legal_q) begin
                ccr      <= alu_nzvc;
                rsp_nzvc <= alu_nzvc;
            end else begin
                rsp_nzvc <= ccr;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_ERR_EN
    // Set is evaluated first so an error arriving with err_clr still leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_sticky <= 1'b0;
        else if ((state == ST_EXEC) && exec_err) err_sticky <= 1'b1;
        else if (err_clr)                       err_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 8-bit ALU on the alu_* ports
// and a register-file/CCR reference model driven by directed and random commands.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_dst = '0;
    logic [ADDR_W-1:0] cmd_srca = '0;
    logic [ADDR_W-1:0] cmd_srcb = '0;
    logic              cmd_useimm = 1'b0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_nzvc;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        rsp_nzvc;
    logic              rsp_err;
    logic [3:0]        ccr;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] rf_m [NREGS];
    logic [3:0] ccr_m;
    logic [7:0] last_data;
    logic [3:0] last_nzvc;
    logic       last_err;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .cmd_useimm (cmd_useimm),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_nzvc   (alu_nzvc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_nzvc   (rsp_nzvc),
        .rsp_err    (rsp_err),
        .ccr        (ccr)
    );

    // Datapath ALU: returns {N,Z,V,C, result}.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        v, c;
        s = '0; p = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1, 4'h5: begin r = a - b; c = (a < b);
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: begin p = a * b; r = p[7:0]; c = (p[15:8] != 8'h00); end
            4'h3: begin if (b == 8'h00) return {4'hF, 8'hFF}; r = a / b; end
            4'h4: begin if (b == 8'h00) return {4'hF, 8'hFF}; r = a % b; end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = ~a;
            4'h9: r = a ^ b;
            default: r = 8'h00;
        endcase
        return {r[7], (r == 8'h00), v, c, r};
    endfunction

    always_comb {alu_nzvc, alu_result} = alu_f(alu_sel, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) rf_m[i] = 8'h00;
        ccr_m = 4'h0;
    endtask

    // One full command: drive, check operands in EXEC, check response and optional backpressure.
    task automatic run_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic useimm, input logic [7:0] imm,
                           input int hold, input bit junk);
        logic        legal, divz;
        logic [7:0]  a_e, b_e, data_e;
        logic [3:0]  nzvc_e, sel_e;
        logic        err_e;
        logic [11:0] res;
        int          waited, lat;

        legal  = (op <= 4'h9);
        a_e    = rf_m[sa];
        b_e    = useimm ? imm : rf_m[sb];
        res    = alu_f(op, a_e, b_e);
        divz   = legal && ((op == 4'h3) || (op == 4'h4)) && (b_e == 8'h00);
        data_e = legal ? res[7:0] : 8'h00;
        nzvc_e = legal ? res[11:8] : ccr_m;
        err_e  = !legal || divz;
        sel_e  = legal ? op : 4'h0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
        cmd_useimm = useimm; cmd_imm = imm;
        waited = 0;
        while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
        if (!cmd_ready) begin check("accept_timeout", 32'd0, 32'd1); cmd_valid = 1'b0; return; end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_cmd_ready", cmd_ready, 1'b0);
        check("exec_alu_sel", alu_sel, sel_e);
        check("exec_alu_a", alu_a, a_e);
        check("exec_alu_b", alu_b, b_e);
        lat = 1;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 10);
        check("latency", lat, 2);
        if (!rsp_valid) return;
        check("rsp_data", rsp_data, data_e);
        check("rsp_err", rsp_err, err_e);
        check("rsp_nzvc", rsp_nzvc, nzvc_e);
        check("ccr", ccr, nzvc_e);
        last_data = rsp_data; last_nzvc = rsp_nzvc; last_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                cmd_valid = 1'b1; cmd_op = 4'h0; cmd_dst = 2'($urandom); cmd_srca = 2'($urandom);
                cmd_useimm = 1'b1; cmd_imm = 8'($urandom);
            end
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_data", rsp_data, data_e);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("drain_rsp_valid", rsp_valid, 1'b0);
        check("drain_cmd_ready", cmd_ready, 1'b1);

        if (legal) ccr_m = nzvc_e;
        if (legal && !divz && (op != 4'h5)) rf_m[dst] = data_e;
    endtask

    // Register readback without writeback: compare against immediate 0 returns the register value.
    task automatic read_reg(input logic [1:0] idx);
        run_cmd(4'h5, 2'd0, idx, 2'd0, 1'b1, 8'h00, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        last_data = '0; last_nzvc = '0; last_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_sel", alu_sel, 4'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_ccr", ccr, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // Preload and signed-overflow add.
        run_cmd(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 0, 1'b0);
        run_cmd(4'h0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 0, 1'b0);
        run_cmd(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 0, 1'b0);
        check("t1_data", last_data, 8'h80);
        check("t1_nzvc", last_nzvc, 4'b1010);
        read_reg(2'd2);
        check("t1_r2", last_data, 8'h80);

        // Subtract to zero, then compare leaves r3 untouched.
        run_cmd(4'h1, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 0, 1'b0);
        check("t2_sub_data", last_data, 8'h00);
        check("t2_sub_nzvc", last_nzvc, 4'b0100);
        run_cmd(4'h5, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 0, 1'b0);
        check("t2_cmp_z", ccr[FLG_Z], 1'b0);
        read_reg(2'd3);
        check("t2_r3", last_data, 8'h00);

        // Divide by zero, then modulo.
        run_cmd(4'h3, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00, 0, 1'b0);
        check("t3_div_err", last_err, 1'b1);
        check("t3_div_data", last_data, 8'hFF);
        check("t3_div_ccr", ccr, 4'hF);
        read_reg(2'd2);
        check("t3_r2", last_data, 8'h80);
        run_cmd(4'h4, 2'd3, 2'd0, 2'd0, 1'b1, 8'h03, 0, 1'b0);
        check("t3_mod_data", last_data, 8'h01);
        read_reg(2'd3);

        // Illegal op: ccr after readback of r3 (1-0) is 0000 and must stay so.
        run_cmd(4'hC, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 0, 1'b0);
        check("t4_err", last_err, 1'b1);
        check("t4_data", last_data, 8'h00);
        check("t4_ccr", ccr, 4'h0);
        read_reg(2'd0); check("t4_r0", last_data, 8'h7F);
        read_reg(2'd1); check("t4_r1", last_data, 8'h01);

        // Backpressure with a competing command during the hold.
        run_cmd(4'h9, 2'd1, 2'd0, 2'd2, 1'b0, 8'h00, 5, 1'b1);
        read_reg(2'd1); check("t5_r1", last_data, 8'hFF);

        // Reset during EXEC aborts the write to r0.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'h0; cmd_dst = 2'd0; cmd_srca = 2'd1;
        cmd_useimm = 1'b1; cmd_imm = 8'h10;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t6_in_exec", cmd_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_alu_a", alu_a, 8'h00);
        check("t6_alu_b", alu_b, 8'h00);
        check("t6_alu_sel", alu_sel, 4'h0);
        check("t6_rsp_valid", rsp_valid, 1'b0);
        check("t6_rsp_data", rsp_data, 8'h00);
        check("t6_rsp_nzvc", rsp_nzvc, 4'h0);
        check("t6_rsp_err", rsp_err, 1'b0);
        check("t6_ccr", ccr, 4'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_cmd_ready", cmd_ready, 1'b1);
        check("t6_no_rsp", rsp_valid, 1'b0);
        read_reg(2'd0); check("t6_r0", last_data, 8'h00);

        // Random commands against the reference model.
        for (int n = 0; n < 60; n++) begin
            run_cmd(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom));
        end
        for (int r = 0; r < NREGS; r++) read_reg(2'(r));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
